// File: rtl/reduction_op_sequencer_if.sv
// Board-side signal bundle for the reduction sequencer: switch/button inputs
// and the LED/status outputs.
interface reduction_op_sequencer_if;
  logic [3:0] switches;
  logic       start;
  logic [2:0] lights;
  logic [1:0] op_sel;
  logic       busy;
  logic       done;

  modport master (output switches, start, input lights, op_sel, busy, done);
  modport slave  (input switches, start, output lights, op_sel, busy, done);
endinterface

// File: rtl/reduction_op_sequencer.sv
// Debounced push-button sequencer that shows NAND, NOR and XNOR reductions of
// a captured 4-bit switch sample, one phase at a time.
module reduction_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input logic                     clk,
  input logic                     reset_n,
  reduction_op_sequencer_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_NAND, S_NOR, S_XNOR, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] timer_q, timer_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          lvl_q, lvl_d;
  logic          armed_q, armed_d;
  logic [3:0]    sample_q, sample_d;
  logic [2:0]    lights_q, lights_d;
  logic [1:0]    op_sel_q, op_sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          stable, go, in_phase, phase_end;

  // Count saturates at DB_MAX; armed_q keeps a held level from re-firing.
  always_comb begin
    lvl_d = bus.start;
    if (db_cnt_q != '0 && bus.start == lvl_q)
      db_cnt_d = (db_cnt_q == DB_MAX) ? db_cnt_q : db_cnt_q + 1'b1;
    else
      db_cnt_d = DW'(1);
    stable  = (db_cnt_d == DB_MAX);
    go      = armed_q && stable && bus.start;
    armed_d = armed_q;
    if (!armed_q && stable && !bus.start) armed_d = 1'b1;
    else if (go)                          armed_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      db_cnt_q <= '0;
      lvl_q    <= 1'b0;
      armed_q  <= 1'b0;
      sample_q <= '0;
      lights_q <= '0;
      op_sel_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      db_cnt_q <= db_cnt_d;
      lvl_q    <= lvl_d;
      armed_q  <= armed_d;
      sample_q <= sample_d;
      lights_q <= lights_d;
      op_sel_q <= op_sel_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign in_phase  = (state_q == S_NAND) || (state_q == S_NOR) || (state_q == S_XNOR);
  assign phase_end = (timer_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_NAND;
      S_NAND:   if (phase_end) state_d = S_NOR;
      S_NOR:    if (phase_end) state_d = S_XNOR;
      S_XNOR:   if (phase_end) state_d = S_DONE;
      S_DONE:   if (go) state_d = S_SAMPLE;
      default:  state_d = S_IDLE;
    endcase
    if (state_d != state_q) timer_d = '0;
    else if (in_phase)      timer_d = timer_q + 1'b1;
    else                    timer_d = '0;
  end

  // Outputs are decoded from the next state so every port comes from a flop.
  always_comb begin
    sample_d = sample_q;
    lights_d = '0;
    op_sel_d = 2'b00;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      S_SAMPLE: begin
        sample_d = bus.switches;
        busy_d   = 1'b1;
      end
      S_NAND: begin
        lights_d = {~&sample_q, 2'b00};
        op_sel_d = 2'b01;
        busy_d   = 1'b1;
      end
      S_NOR: begin
        lights_d = {~&sample_q, ~|sample_q, 1'b0};
        op_sel_d = 2'b10;
        busy_d   = 1'b1;
      end
      S_XNOR: begin
        lights_d = {~&sample_q, ~|sample_q, ~^sample_q};
        op_sel_d = 2'b11;
        busy_d   = 1'b1;
      end
      S_DONE: begin
        lights_d = lights_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.lights = lights_q;
  assign bus.op_sel = op_sel_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_reduction_op_sequencer.sv
// Directed bench for reduction_op_sequencer at default parameters.
module tb_reduction_op_sequencer;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   passed = 0;

  reduction_op_sequencer_if bus();

  reduction_op_sequencer #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [3:0] sw;
    logic [2:0] l_nand;
    logic [2:0] l_nor;
    logic [2:0] l_fin;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] outs();
    return {25'd0, bus.busy, bus.done, bus.op_sel, bus.lights};
  endfunction

  // Release for 4 edges, press for 4 edges; returns at the negedge after go.
  task automatic press(input string tag);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, "_early_go"}, {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_sample"}, outs(), {25'd0, 7'b1_0_00_000});
  endtask

  // Called at the SAMPLE observation; follows the run into DONE.
  task automatic run_to_done(input vec_t v, input bit mid, input string tag);
    int bn = 1;
    int n1 = 0;
    int n2 = 0;
    int n3 = 0;
    int k  = 0;
    bit bad1 = 0;
    bit bad2 = 0;
    bit bad3 = 0;
    while (!bus.done && k < 60) begin
      @(negedge clk);
      k++;
      if (mid) bus.start = !(k >= 1 && k <= 4);
      if (bus.busy) bn++;
      case (bus.op_sel)
        2'b01: begin
          n1++;
          if (bus.lights !== v.l_nand) bad1 = 1;
          bus.switches = ~v.sw;
        end
        2'b10: begin n2++; if (bus.lights !== v.l_nor) bad2 = 1; end
        2'b11: begin n3++; if (bus.lights !== v.l_fin) bad3 = 1; end
        default: ;
      endcase
    end
    chk({tag, "_done_reached"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_nand_cycles"}, n1, 8);
    chk({tag, "_nor_cycles"}, n2, 8);
    chk({tag, "_xnor_cycles"}, n3, 8);
    chk({tag, "_busy_cycles"}, bn, 25);
    chk({tag, "_phase_lights_bad"}, {29'd0, bad1, bad2, bad3}, 32'd0);
    chk({tag, "_done_outs"}, outs(), {25'd0, 4'b0_1_00, v.l_fin});
  endtask

  // Start stays high: DONE must hold without a restart.
  task automatic hold_done(input vec_t v, input string tag);
    bit moved = 0;
    repeat (6) begin
      @(negedge clk);
      if (outs() !== {25'd0, 4'b0_1_00, v.l_fin}) moved = 1;
    end
    chk({tag, "_done_held"}, {31'd0, moved}, 32'd0);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    int   k;

    vecs[0] = '{sw: 4'b1111, l_nand: 3'b000, l_nor: 3'b000, l_fin: 3'b001};
    vecs[1] = '{sw: 4'b0000, l_nand: 3'b100, l_nor: 3'b110, l_fin: 3'b111};
    vecs[2] = '{sw: 4'b1010, l_nand: 3'b100, l_nor: 3'b100, l_fin: 3'b101};
    vecs[3] = '{sw: 4'b0111, l_nand: 3'b100, l_nor: 3'b100, l_fin: 3'b100};
    vecs[4] = '{sw: 4'b1110, l_nand: 3'b100, l_nor: 3'b100, l_fin: 3'b100};

    reset_n = 1'b0;
    bus.start = 1'b0;
    bus.switches = 4'b0000;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    reset_n = 1'b1;

    // Short bounces never arm or fire.
    seen = 0;
    for (int i = 0; i < 13; i++) begin
      bus.start = (i < 3) || (i >= 4 && i < 7);
      @(negedge clk);
      if (outs() !== 32'd0) seen = 1;
    end
    chk("bounce_no_go", {31'd0, seen}, 32'd0);

    foreach (vecs[i]) begin
      v = vecs[i];
      bus.switches = v.sw;
      press($sformatf("vec%0d", i));
      run_to_done(v, 1'b0, $sformatf("vec%0d", i));
      hold_done(v, $sformatf("vec%0d", i));
    end

    // A press while busy is swallowed; button must be released to re-fire.
    v = vecs[2];
    bus.switches = v.sw;
    press("midpress");
    run_to_done(v, 1'b1, "midpress");
    hold_done(v, "midpress");

    // Reset during NOR with the button held down.
    v = vecs[1];
    bus.switches = v.sw;
    press("rst");
    k = 0;
    while (bus.op_sel !== 2'b10 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_nor", {30'd0, bus.op_sel}, 32'd2);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_outs_cleared", outs(), 32'd0);
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.busy) seen = 1;
    end
    chk("rst_held_no_go", {31'd0, seen}, 32'd0);
    press("after_rst");
    run_to_done(v, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
